mem_access_unit: RTL and testbench

- Multi-cycle load/store unit between the core datapath and the data memory.
- Store direction: narrows store data to byte or halfword, replicates it across byte lanes, and generates byte enables.
- Load direction: selects the addressed lane and sign- or zero-extends it to 32 bits.
- Uses a valid/ready handshake toward the core and a req/ack handshake toward memory, with alignment checking and an ack timeout.

---
 rtl/mips_mem_pkg.sv | 28 ++
 rtl/mem_lane_ext.sv | 43 ++++
 rtl/mem_access_unit.sv | 200 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types for the load/store unit: size codes, FSM states,
// data width and the byte-lane mapping helper.
package mips_mem_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Big-endian puts byte 0 in lane 3, i.e. lane = 3 - offset.
  function automatic logic [1:0] lane_of(
    input logic [1:0] off,
    input logic       big
  );
    return big ? ~off : off;
  endfunction

endpackage

// File: rtl/mem_lane_ext.sv
// Load-side lane select: picks the addressed byte/halfword of a
// memory word and sign- or zero-extends it to DATA_W bits.
module mem_lane_ext
  import mips_mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        addr_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] ext_o
);

  logic [1:0]  lane;
  logic [7:0]  b;
  logic [15:0] h;

  assign lane = lane_of(addr_i, BIG_ENDIAN);
  assign h    = lane[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    b = rdata_i[7:0];
    unique case (lane)
      2'd0: b = rdata_i[7:0];
      2'd1: b = rdata_i[15:8];
      2'd2: b = rdata_i[23:16];
      2'd3: b = rdata_i[31:24];
    endcase
  end

  always_comb begin
    ext_o = rdata_i;
    unique case (size_e'(size_i))
      SZ_BYTE: ext_o = unsigned_i ? {24'b0, b}
                                  : {{24{b[7]}}, b};
      SZ_HALF: ext_o = unsigned_i ? {16'b0, h}
                                  : {{16{h[15]}}, h};
      default: ext_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: core valid/ready in, memory req/ack
// out, with store lane packing, load extension and ack timeout.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter bit          BIG_ENDIAN  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        sz_q, sz_d;
  logic [1:0]        off_q, off_d;
  logic              uns_q, uns_d;

  size_e             req_sz;
  logic [1:0]        st_lane;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata;
  logic              bad;
  logic [DATA_W-1:0] ld_ext;

  assign req_sz  = size_e'(req_size);
  assign st_lane = lane_of(req_addr[1:0], BIG_ENDIAN);

  assign bad = (req_sz == SZ_RSVD)
             || (req_sz == SZ_HALF && req_addr[0])
             || (req_sz == SZ_WORD && req_addr[1:0] != 2'b00);

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = req_wdata;
    unique case (req_sz)
      SZ_BYTE: begin
        st_be    = 4'b0001 << st_lane;
        st_wdata = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be    = st_lane[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = req_wdata;
      end
    endcase
  end

  mem_lane_ext #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_ext (
    .rdata_i   (mem_rdata),
    .addr_i    (off_q),
    .size_i    (sz_q),
    .unsigned_i(uns_q),
    .ext_o     (ld_ext)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    sz_d        = sz_q;
    off_d       = off_q;
    uns_d       = uns_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          sz_d        = req_size;
          off_d       = req_addr[1:0];
          uns_d       = req_unsigned;
          req_ready_d = 1'b0;
          if (bad) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = ST_ACCESS;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_be_d    = req_we ? st_be : 4'b1111;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = req_we ? st_wdata : '0;
          end
        end
      end
      ST_ACCESS: begin
        // Ack takes priority over a timeout reached in the same cycle.
        if (mem_ack || cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !mem_ack;
          rsp_rdata_d = (mem_ack && !mem_we_q) ? ld_ext : '0;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_be_d    = '0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      sz_q        <= '0;
      off_q       <= '0;
      uns_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      sz_q        <= sz_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a short ack timeout.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .TIMEOUT_CYC(4),
    .BIG_ENDIAN (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request pulse; returns just after the handshake edge.
  task automatic req(input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a,
                     input logic [31:0] wd);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic ack1(input logic [31:0] rd);
    mem_rdata = rd;
    mem_ack   = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  logic [1:0]  bad_sz [3];
  logic [31:0] bad_ad [3];

  initial begin
    int n;
    int seen;
    int acc_n, hs, h1, h2, r1, r2, pulses, wide, rdy_bad, prev_v;

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    mem_rdata    = '0;
    mem_ack      = 1'b0;
    tick();
    tick();
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_memreq", {31'b0, mem_req}, 32'd0);
    check("rst_rspv", {31'b0, rsp_valid}, 32'd0);
    check("rst_be", {28'b0, mem_be}, 32'd0);
    rst_n = 1'b1;
    tick();

    // lb 0x101, ack on first ACCESS cycle
    req(1'b0, 2'b00, 1'b0, 32'h101, 32'h0);
    check("lb_memreq", {31'b0, mem_req}, 32'd1);
    check("lb_addr", mem_addr, 32'h100);
    check("lb_be", {28'b0, mem_be}, 32'hF);
    check("lb_wdata", mem_wdata, 32'h0);
    check("lb_ready", {31'b0, req_ready}, 32'd0);
    check("lb_early", {31'b0, rsp_valid}, 32'd0);
    ack1(32'h123480FF);
    check("lb_rspv", {31'b0, rsp_valid}, 32'd1);
    check("lb_rdata", rsp_rdata, 32'hFFFFFF80);
    check("lb_err", {31'b0, rsp_err}, 32'd0);
    tick();
    check("lb_rspv_off", {31'b0, rsp_valid}, 32'd0);
    check("lb_ready_back", {31'b0, req_ready}, 32'd1);

    req(1'b0, 2'b00, 1'b1, 32'h101, 32'h0);
    ack1(32'h123480FF);
    check("lbu_rdata", rsp_rdata, 32'h00000080);
    tick();

    // sh 0x12 with one wait cycle
    req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF);
    check("sh_addr", mem_addr, 32'h10);
    check("sh_we", {31'b0, mem_we}, 32'd1);
    check("sh_be", {28'b0, mem_be}, 32'hC);
    check("sh_wdata", mem_wdata, 32'hBEEFBEEF);
    tick();
    check("sh_hold_req", {31'b0, mem_req}, 32'd1);
    check("sh_hold_be", {28'b0, mem_be}, 32'hC);
    ack1(32'hDEADBEEF);
    check("sh_rspv", {31'b0, rsp_valid}, 32'd1);
    check("sh_rdata", rsp_rdata, 32'h0);
    check("sh_err", {31'b0, rsp_err}, 32'd0);
    tick();

    // sb lane 3 and lw pass-through
    req(1'b1, 2'b00, 1'b0, 32'h203, 32'h000000A5);
    check("sb_be", {28'b0, mem_be}, 32'h8);
    check("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    ack1(32'h0);
    tick();
    req(1'b0, 2'b10, 1'b1, 32'h208, 32'h0);
    ack1(32'h89ABCDEF);
    check("lw_rdata", rsp_rdata, 32'h89ABCDEF);
    tick();

    // Illegal requests: no memory cycle, error at t+1
    bad_sz[0] = 2'b10; bad_ad[0] = 32'h6;
    bad_sz[1] = 2'b11; bad_ad[1] = 32'h0;
    bad_sz[2] = 2'b01; bad_ad[2] = 32'h3;
    for (int i = 0; i < 3; i++) begin
      req(1'b0, bad_sz[i], 1'b0, bad_ad[i], 32'h0);
      check($sformatf("bad%0d_memreq", i), {31'b0, mem_req}, 32'd0);
      check($sformatf("bad%0d_rspv", i), {31'b0, rsp_valid}, 32'd1);
      check($sformatf("bad%0d_err", i), {31'b0, rsp_err}, 32'd1);
      tick();
      check($sformatf("bad%0d_ready", i), {31'b0, req_ready}, 32'd1);
    end

    // sw with no ack: timeout after 4 cycles of mem_req
    req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
    check("to_be", {28'b0, mem_be}, 32'hF);
    check("to_wdata", mem_wdata, 32'h11223344);
    n = 0;
    for (int i = 0; i < 20 && mem_req; i++) begin
      n++;
      tick();
    end
    check("to_req_cycles", n, 32'd4);
    check("to_rspv", {31'b0, rsp_valid}, 32'd1);
    check("to_err", {31'b0, rsp_err}, 32'd1);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("stray_ack_rspv", {31'b0, rsp_valid}, 32'd0);
    tick();
    check("stray_ack_rspv2", {31'b0, rsp_valid}, 32'd0);
    check("stray_ack_ready", {31'b0, req_ready}, 32'd1);

    // Reset during ACCESS
    req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_memreq", {31'b0, mem_req}, 32'd0);
    check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    check("rst_mid_norsp", seen, 32'd0);
    req(1'b0, 2'b01, 1'b1, 32'h2, 32'h0);
    ack1(32'h80010000);
    check("lhu_rdata", rsp_rdata, 32'h00008001);
    tick();

    // Back-to-back with req_valid held, ack on 3rd ACCESS cycle
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h40;
    mem_rdata    = 32'hCAFEF00D;
    acc_n = 0; hs = 0; h1 = -1; h2 = -1; r1 = -1; r2 = -1;
    pulses = 0; wide = 0; rdy_bad = 0; prev_v = 0;
    for (int i = 0; i < 24; i++) begin
      if (hs == 2) req_valid = 1'b0;
      if (mem_req) begin
        acc_n++;
        mem_ack = (acc_n == 3);
      end else begin
        acc_n   = 0;
        mem_ack = 1'b0;
      end
      if ((mem_req || rsp_valid) && req_ready) rdy_bad++;
      if (rsp_valid) begin
        pulses++;
        if (prev_v != 0) wide++;
        if (r1 < 0) r1 = i; else r2 = i;
        check("b2b_rdata", rsp_rdata, 32'hCAFEF00D);
      end
      prev_v = rsp_valid ? 1 : 0;
      if (req_valid && req_ready) begin
        hs++;
        if (h1 < 0) h1 = i; else h2 = i;
      end
      tick();
    end
    mem_ack = 1'b0;
    check("b2b_hs", hs, 32'd2);
    check("b2b_pulses", pulses, 32'd2);
    check("b2b_wide", wide, 32'd0);
    check("b2b_ready_low", rdy_bad, 32'd0);
    check("b2b_lat1", r1 - h1, 32'd4);
    check("b2b_accept2", h2 - r1, 32'd1);
    check("b2b_lat2", r2 - h2, 32'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
